// File: rtl/reservation_station_if.sv
// Dispatch/CDB/issue bundle for the arithmetic reservation station.
interface reservation_station_if #(
   parameter int ROB_W = 4,
   parameter int OP_W  = 6
);
   logic             rdy;
   logic             misbranch_flag;
   logic             ena_from_dsp;
   logic [OP_W-1:0]  openum_from_dsp;
   logic [31:0]      V1_from_dsp;
   logic [31:0]      V2_from_dsp;
   logic [ROB_W-1:0] Q1_from_dsp;
   logic [ROB_W-1:0] Q2_from_dsp;
   logic [31:0]      pc_from_dsp;
   logic [31:0]      imm_from_dsp;
   logic [ROB_W-1:0] rob_id_from_dsp;
   logic             valid_from_arith_cdb;
   logic [ROB_W-1:0] rob_id_from_arith_cdb;
   logic [31:0]      result_from_arith_cdb;
   logic             valid_from_ls_cdb;
   logic [ROB_W-1:0] rob_id_from_ls_cdb;
   logic [31:0]      result_from_ls_cdb;
   logic             full_to_if;
   logic             ena_to_alu;
   logic [OP_W-1:0]  openum_to_alu;
   logic [31:0]      V1_to_alu;
   logic [31:0]      V2_to_alu;
   logic [31:0]      pc_to_alu;
   logic [31:0]      imm_to_alu;
   logic [ROB_W-1:0] rob_id_to_alu;

   modport master (
      output rdy, misbranch_flag, ena_from_dsp, openum_from_dsp, V1_from_dsp, V2_from_dsp,
             Q1_from_dsp, Q2_from_dsp, pc_from_dsp, imm_from_dsp, rob_id_from_dsp,
             valid_from_arith_cdb, rob_id_from_arith_cdb, result_from_arith_cdb,
             valid_from_ls_cdb, rob_id_from_ls_cdb, result_from_ls_cdb,
      input  full_to_if, ena_to_alu, openum_to_alu, V1_to_alu, V2_to_alu,
             pc_to_alu, imm_to_alu, rob_id_to_alu
   );

   modport slave (
      input  rdy, misbranch_flag, ena_from_dsp, openum_from_dsp, V1_from_dsp, V2_from_dsp,
             Q1_from_dsp, Q2_from_dsp, pc_from_dsp, imm_from_dsp, rob_id_from_dsp,
             valid_from_arith_cdb, rob_id_from_arith_cdb, result_from_arith_cdb,
             valid_from_ls_cdb, rob_id_from_ls_cdb, result_from_ls_cdb,
      output full_to_if, ena_to_alu, openum_to_alu, V1_to_alu, V2_to_alu,
             pc_to_alu, imm_to_alu, rob_id_to_alu
   );
endinterface

// File: rtl/reservation_station.sv
// Arithmetic/branch reservation station: buffers dispatched ops, snoops both
// CDB channels for pending operands and issues the lowest ready slot each cycle.
module reservation_station #(
   parameter int RS_SIZE = 16,
   parameter int ROB_W   = 4,
   parameter int OP_W    = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   reservation_station_if.slave  rs
);
   localparam int IDX_W = $clog2(RS_SIZE);
   localparam int CNT_W = IDX_W + 1;
   localparam logic [CNT_W-1:0] FULL_TH    = CNT_W'(RS_SIZE - 1);
   localparam logic [OP_W-1:0]  OPENUM_NOP = '0;
   localparam logic [ROB_W-1:0] ZERO_ROB   = '0;

   logic [RS_SIZE-1:0] busy_q, busy_d;
   logic [OP_W-1:0]    op_q   [RS_SIZE];
   logic [OP_W-1:0]    op_d   [RS_SIZE];
   logic [31:0]        v1_q   [RS_SIZE];
   logic [31:0]        v1_d   [RS_SIZE];
   logic [31:0]        v2_q   [RS_SIZE];
   logic [31:0]        v2_d   [RS_SIZE];
   logic [ROB_W-1:0]   q1_q   [RS_SIZE];
   logic [ROB_W-1:0]   q1_d   [RS_SIZE];
   logic [ROB_W-1:0]   q2_q   [RS_SIZE];
   logic [ROB_W-1:0]   q2_d   [RS_SIZE];
   logic [31:0]        pc_q   [RS_SIZE];
   logic [31:0]        pc_d   [RS_SIZE];
   logic [31:0]        imm_q  [RS_SIZE];
   logic [31:0]        imm_d  [RS_SIZE];
   logic [ROB_W-1:0]   rob_q  [RS_SIZE];
   logic [ROB_W-1:0]   rob_d  [RS_SIZE];

   logic               ena_out_q, ena_out_d;
   logic [OP_W-1:0]    op_out_q, op_out_d;
   logic [31:0]        v1_out_q, v1_out_d;
   logic [31:0]        v2_out_q, v2_out_d;
   logic [31:0]        pc_out_q, pc_out_d;
   logic [31:0]        imm_out_q, imm_out_d;
   logic [ROB_W-1:0]   rob_out_q, rob_out_d;

   logic               iss_found, alloc_found;
   logic [IDX_W-1:0]   iss_idx, alloc_idx;
   logic [CNT_W-1:0]   busy_cnt;

   logic               a_vld, l_vld;
   logic [ROB_W-1:0]   a_tag, l_tag;
   logic [31:0]        a_dat, l_dat;

   assign a_vld = rs.valid_from_arith_cdb;
   assign a_tag = rs.rob_id_from_arith_cdb;
   assign a_dat = rs.result_from_arith_cdb;
   assign l_vld = rs.valid_from_ls_cdb;
   assign l_tag = rs.rob_id_from_ls_cdb;
   assign l_dat = rs.result_from_ls_cdb;

   // Returns {tag, value}; arith CDB wins over LS, and tag 0 never matches.
   function automatic logic [ROB_W+31:0] resolve(
      input logic [ROB_W-1:0] tag, input logic [31:0] val,
      input logic av, input logic [ROB_W-1:0] at, input logic [31:0] ad,
      input logic lv, input logic [ROB_W-1:0] lt, input logic [31:0] ld);
      logic [ROB_W+31:0] r;
      r = {tag, val};
      if (tag != ZERO_ROB) begin
         if (av && at == tag)      r = {ZERO_ROB, ad};
         else if (lv && lt == tag) r = {ZERO_ROB, ld};
      end
      return r;
   endfunction

   always_comb begin
      busy_cnt = '0;
      for (int i = 0; i < RS_SIZE; i++) busy_cnt = busy_cnt + CNT_W'(busy_q[i]);
   end

   // Keeps one slot spare for the dispatcher's in-flight register stage.
   assign rs.full_to_if = (busy_cnt >= FULL_TH);

   always_comb begin
      busy_d    = busy_q;
      op_d      = op_q;
      v1_d      = v1_q;
      v2_d      = v2_q;
      q1_d      = q1_q;
      q2_d      = q2_q;
      pc_d      = pc_q;
      imm_d     = imm_q;
      rob_d     = rob_q;
      ena_out_d = 1'b0;
      op_out_d  = op_out_q;
      v1_out_d  = v1_out_q;
      v2_out_d  = v2_out_q;
      pc_out_d  = pc_out_q;
      imm_out_d = imm_out_q;
      rob_out_d = rob_out_q;

      iss_found   = 1'b0;
      iss_idx     = '0;
      alloc_found = 1'b0;
      alloc_idx   = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (busy_q[i] && q1_q[i] == ZERO_ROB && q2_q[i] == ZERO_ROB) begin
            iss_found = 1'b1;
            iss_idx   = IDX_W'(i);
         end
         if (!busy_q[i]) begin
            alloc_found = 1'b1;
            alloc_idx   = IDX_W'(i);
         end
      end

      if (rs.rdy) begin
         if (rs.misbranch_flag) begin
            busy_d = '0;
         end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
               if (busy_q[i]) begin
                  {q1_d[i], v1_d[i]} = resolve(q1_q[i], v1_q[i], a_vld, a_tag, a_dat, l_vld, l_tag, l_dat);
                  {q2_d[i], v2_d[i]} = resolve(q2_q[i], v2_q[i], a_vld, a_tag, a_dat, l_vld, l_tag, l_dat);
               end
            end
            if (iss_found) begin
               ena_out_d       = 1'b1;
               op_out_d        = op_q[iss_idx];
               v1_out_d        = v1_q[iss_idx];
               v2_out_d        = v2_q[iss_idx];
               pc_out_d        = pc_q[iss_idx];
               imm_out_d       = imm_q[iss_idx];
               rob_out_d       = rob_q[iss_idx];
               busy_d[iss_idx] = 1'b0;
            end
            // Allocation only looks at slots free before this edge, so it never
            // collides with the slot being issued.
            if (rs.ena_from_dsp && alloc_found) begin
               busy_d[alloc_idx] = 1'b1;
               op_d[alloc_idx]   = rs.openum_from_dsp;
               pc_d[alloc_idx]   = rs.pc_from_dsp;
               imm_d[alloc_idx]  = rs.imm_from_dsp;
               rob_d[alloc_idx]  = rs.rob_id_from_dsp;
               {q1_d[alloc_idx], v1_d[alloc_idx]} =
                  resolve(rs.Q1_from_dsp, rs.V1_from_dsp, a_vld, a_tag, a_dat, l_vld, l_tag, l_dat);
               {q2_d[alloc_idx], v2_d[alloc_idx]} =
                  resolve(rs.Q2_from_dsp, rs.V2_from_dsp, a_vld, a_tag, a_dat, l_vld, l_tag, l_dat);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q    <= '0;
         ena_out_q <= 1'b0;
         op_out_q  <= OPENUM_NOP;
         v1_out_q  <= '0;
         v2_out_q  <= '0;
         pc_out_q  <= '0;
         imm_out_q <= '0;
         rob_out_q <= '0;
      end else begin
         busy_q    <= busy_d;
         ena_out_q <= ena_out_d;
         op_out_q  <= op_out_d;
         v1_out_q  <= v1_out_d;
         v2_out_q  <= v2_out_d;
         pc_out_q  <= pc_out_d;
         imm_out_q <= imm_out_d;
         rob_out_q <= rob_out_d;
      end
   end

   // Entry payload is qualified by busy, so it needs no reset.
   always_ff @(posedge clk) begin
      op_q  <= op_d;
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      q1_q  <= q1_d;
      q2_q  <= q2_d;
      pc_q  <= pc_d;
      imm_q <= imm_d;
      rob_q <= rob_d;
   end

   assign rs.ena_to_alu    = ena_out_q;
   assign rs.openum_to_alu = op_out_q;
   assign rs.V1_to_alu     = v1_out_q;
   assign rs.V2_to_alu     = v2_out_q;
   assign rs.pc_to_alu     = pc_out_q;
   assign rs.imm_to_alu    = imm_out_q;
   assign rs.rob_id_to_alu = rob_out_q;
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: issue latency, CDB wakeup/forwarding,
// fill/full behaviour, rdy freeze, misbranch flush and asynchronous reset.
module tb_reservation_station;
   logic clk;
   logic rst_n;
   int   total;
   int   passed;

   reservation_station_if #(.ROB_W(4), .OP_W(6)) bus ();

   reservation_station #(.RS_SIZE(16), .ROB_W(4), .OP_W(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rs    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      bus.ena_from_dsp         = 1'b0;
      bus.valid_from_arith_cdb = 1'b0;
      bus.valid_from_ls_cdb    = 1'b0;
      bus.misbranch_flag       = 1'b0;
   endtask

   task automatic disp(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [3:0] q1, input logic [3:0] q2,
                       input logic [31:0] pc, input logic [31:0] imm, input logic [3:0] rob);
      bus.ena_from_dsp    = 1'b1;
      bus.openum_from_dsp = op;
      bus.V1_from_dsp     = v1;
      bus.V2_from_dsp     = v2;
      bus.Q1_from_dsp     = q1;
      bus.Q2_from_dsp     = q2;
      bus.pc_from_dsp     = pc;
      bus.imm_from_dsp    = imm;
      bus.rob_id_from_dsp = rob;
   endtask

   task automatic arith_cdb(input logic [3:0] tag, input logic [31:0] dat);
      bus.valid_from_arith_cdb  = 1'b1;
      bus.rob_id_from_arith_cdb = tag;
      bus.result_from_arith_cdb = dat;
   endtask

   task automatic ls_cdb(input logic [3:0] tag, input logic [31:0] dat);
      bus.valid_from_ls_cdb  = 1'b1;
      bus.rob_id_from_ls_cdb = tag;
      bus.result_from_ls_cdb = dat;
   endtask

   initial begin
      total  = 0;
      passed = 0;
      rst_n  = 1'b0;
      bus.rdy = 1'b1;
      bus.misbranch_flag = 1'b0;
      bus.ena_from_dsp = 1'b0;
      bus.openum_from_dsp = '0;
      bus.V1_from_dsp = '0;
      bus.V2_from_dsp = '0;
      bus.Q1_from_dsp = '0;
      bus.Q2_from_dsp = '0;
      bus.pc_from_dsp = '0;
      bus.imm_from_dsp = '0;
      bus.rob_id_from_dsp = '0;
      bus.valid_from_arith_cdb = 1'b0;
      bus.rob_id_from_arith_cdb = '0;
      bus.result_from_arith_cdb = '0;
      bus.valid_from_ls_cdb = 1'b0;
      bus.rob_id_from_ls_cdb = '0;
      bus.result_from_ls_cdb = '0;

      #12;
      chk("rst_ena", bus.ena_to_alu, 0);
      chk("rst_full", bus.full_to_if, 0);
      chk("rst_op", bus.openum_to_alu, 0);
      chk("rst_v1", bus.V1_to_alu, 0);
      chk("rst_rob", bus.rob_id_to_alu, 0);
      rst_n = 1'b1;

      // Ready ADD: issues one edge after it is written
      disp(6'd1, 32'd5, 32'd7, 4'd0, 4'd0, 32'h100, 32'h10, 4'd3);
      tick();
      chk("add_not_yet", bus.ena_to_alu, 0);
      tick();
      chk("add_ena", bus.ena_to_alu, 1);
      chk("add_op", bus.openum_to_alu, 1);
      chk("add_v1", bus.V1_to_alu, 5);
      chk("add_v2", bus.V2_to_alu, 7);
      chk("add_pc", bus.pc_to_alu, 32'h100);
      chk("add_imm", bus.imm_to_alu, 32'h10);
      chk("add_rob", bus.rob_id_to_alu, 3);
      tick();
      chk("add_ena_drop", bus.ena_to_alu, 0);
      chk("add_v1_hold", bus.V1_to_alu, 5);

      // Pending Q1=2 woken by arith CDB three edges later
      disp(6'd2, 32'd0, 32'd9, 4'd2, 4'd0, 32'h104, 32'h0, 4'd4);
      tick();
      tick();
      tick();
      chk("wake_wait", bus.ena_to_alu, 0);
      arith_cdb(4'd2, 32'h1234);
      tick();
      chk("wake_edge", bus.ena_to_alu, 0);
      tick();
      chk("wake_ena", bus.ena_to_alu, 1);
      chk("wake_v1", bus.V1_to_alu, 32'h1234);
      chk("wake_v2", bus.V2_to_alu, 9);
      chk("wake_rob", bus.rob_id_to_alu, 4);
      tick();
      chk("wake_drop", bus.ena_to_alu, 0);

      // Dispatch-time forwarding from LS CDB
      disp(6'd3, 32'd1, 32'd0, 4'd0, 4'd5, 32'h108, 32'h0, 4'd6);
      ls_cdb(4'd5, 32'hAA);
      tick();
      chk("fwd_not_yet", bus.ena_to_alu, 0);
      tick();
      chk("fwd_ena", bus.ena_to_alu, 1);
      chk("fwd_v1", bus.V1_to_alu, 1);
      chk("fwd_v2", bus.V2_to_alu, 32'hAA);
      chk("fwd_rob", bus.rob_id_to_alu, 6);

      // Both CDBs match the same tag: arith data wins
      disp(6'd4, 32'd0, 32'd2, 4'd7, 4'd0, 32'h10C, 32'h0, 4'd8);
      arith_cdb(4'd7, 32'h11);
      ls_cdb(4'd7, 32'h22);
      tick();
      tick();
      chk("prio_ena", bus.ena_to_alu, 1);
      chk("prio_v1", bus.V1_to_alu, 32'h11);

      // A CDB broadcasting tag 0 must not overwrite a ready operand
      disp(6'd5, 32'h55, 32'h66, 4'd0, 4'd0, 32'h110, 32'h0, 4'd9);
      arith_cdb(4'd0, 32'h99);
      tick();
      tick();
      chk("tag0_ena", bus.ena_to_alu, 1);
      chk("tag0_v1", bus.V1_to_alu, 32'h55);
      tick();

      // Fill 15 slots waiting on tag 9, then release them
      for (int i = 0; i < 15; i++) begin
         disp(6'd6, 32'd0, 32'd3, 4'd9, 4'd0, 32'h1000 + 32'(i), 32'h0, 4'((i % 15) + 1));
         tick();
         if (i == 13) chk("fill_14_full", bus.full_to_if, 0);
      end
      chk("fill_15_full", bus.full_to_if, 1);
      chk("fill_no_issue", bus.ena_to_alu, 0);
      arith_cdb(4'd9, 32'hBEEF);
      tick();
      chk("fill_wake_edge", bus.ena_to_alu, 0);
      chk("fill_wake_full", bus.full_to_if, 1);
      tick();
      chk("fill_first_ena", bus.ena_to_alu, 1);
      chk("fill_first_pc", bus.pc_to_alu, 32'h1000);
      chk("fill_first_v1", bus.V1_to_alu, 32'hBEEF);
      chk("fill_full_drop", bus.full_to_if, 0);
      for (int i = 1; i < 15; i++) begin
         tick();
         chk("fill_order_ena", bus.ena_to_alu, 1);
         chk("fill_order_pc", bus.pc_to_alu, 32'h1000 + 32'(i));
      end
      tick();
      chk("fill_done_ena", bus.ena_to_alu, 0);
      chk("fill_done_full", bus.full_to_if, 0);

      // rdy low freezes issue for one cycle
      disp(6'd7, 32'd4, 32'd4, 4'd0, 4'd0, 32'h200, 32'h0, 4'd5);
      tick();
      bus.rdy = 1'b0;
      tick();
      chk("rdy_freeze", bus.ena_to_alu, 0);
      bus.rdy = 1'b1;
      tick();
      chk("rdy_resume_ena", bus.ena_to_alu, 1);
      chk("rdy_resume_pc", bus.pc_to_alu, 32'h200);
      tick();

      // Misbranch with concurrent dispatch and wakeup
      for (int i = 0; i < 4; i++) begin
         disp(6'd8, 32'd0, 32'd0, 4'hA, 4'd0, 32'h2000 + 32'(i), 32'h0, 4'd1);
         tick();
      end
      bus.misbranch_flag = 1'b1;
      disp(6'd9, 32'd1, 32'd1, 4'd0, 4'd0, 32'h2100, 32'h0, 4'd7);
      arith_cdb(4'hA, 32'h1);
      tick();
      chk("flush_ena0", bus.ena_to_alu, 0);
      chk("flush_full", bus.full_to_if, 0);
      tick();
      chk("flush_ena1", bus.ena_to_alu, 0);
      tick();
      chk("flush_ena2", bus.ena_to_alu, 0);
      arith_cdb(4'hA, 32'h1);
      tick();
      tick();
      chk("flush_stale_wake", bus.ena_to_alu, 0);

      // Asynchronous reset with 15 busy slots and an issue in flight
      for (int i = 0; i < 14; i++) begin
         disp(6'd10, 32'd0, 32'd0, 4'hB, 4'd0, 32'h3000 + 32'(i), 32'h0, 4'd1);
         tick();
      end
      disp(6'd11, 32'd8, 32'd8, 4'd0, 4'd0, 32'h3100, 32'h0, 4'd2);
      tick();
      chk("ares_pre_full", bus.full_to_if, 1);
      disp(6'd10, 32'd0, 32'd0, 4'hB, 4'd0, 32'h3200, 32'h0, 4'd1);
      tick();
      chk("ares_pre_ena", bus.ena_to_alu, 1);
      chk("ares_pre_pc", bus.pc_to_alu, 32'h3100);
      chk("ares_pre_full2", bus.full_to_if, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ares_ena", bus.ena_to_alu, 0);
      chk("ares_full", bus.full_to_if, 0);
      chk("ares_pc", bus.pc_to_alu, 0);
      chk("ares_op", bus.openum_to_alu, 0);
      #1;
      rst_n = 1'b1;
      arith_cdb(4'hB, 32'h7);
      tick();
      tick();
      chk("ares_post_ena", bus.ena_to_alu, 0);
      chk("ares_post_full", bus.full_to_if, 0);
      tick();
      chk("ares_post_ena2", bus.ena_to_alu, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
